aes_128: RTL and testbench
==========================

AES_128 -- requirements
Module: aes_128

Interface
REQ-001 Parameters: none; the block SHALL be fixed AES-128 (128-bit block, 128-bit key, 10 rounds).
REQ-002 Clk  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-003 Rst  input  1  synchronous, active-high reset, sampled on the Clk rising edge.
REQ-004 ProgramSelector  input  1  1 = encrypt, 0 = decrypt; sampled only at request acceptance.
REQ-005 UserText  input  128  plaintext (encrypt) or ciphertext (decrypt).
REQ-006 Key  input  128  cipher key.
REQ-007 ReadyKey  input  1  Key is valid.
REQ-008 ReadRy  input  1  UserText is valid.
REQ-009 WriteRy  input  1  consumer accepts Result.
REQ-010 ReadEn  output  1  one-cycle acknowledge that the inputs were captured.
REQ-011 WriteEn  output  1  Result valid.
REQ-012 Result  output  128  ciphertext (encrypt) or plaintext (decrypt).

Function
REQ-013 Byte layout SHALL be row-major over the AES state: bits [127:120] = s(r0,c0), [119:112] = s(r0,c1), [111:104] = s(r0,c2), [103:96] = s(r0,c3), [95:88] = s(r1,c0), and so on to [7:0] = s(r3,c3); Key and Result SHALL use the same layout.
REQ-014 FSM states SHALL be IDLE, KEYEXP, CRYPT and DONE; all outputs SHALL be registered.
REQ-015 IDLE: on an edge with ReadyKey=1 and ReadRy=1, the block SHALL latch UserText, Key and ProgramSelector, assert ReadEn for exactly the following cycle, and go to KEYEXP.
REQ-016 IDLE with either ReadyKey or ReadRy low SHALL do nothing: ReadEn=0 and Result held.
REQ-017 KEYEXP: 10 edges SHALL compute round keys rk1..rk10 (FIPS-197 schedule: RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36) and store all 11 round keys; the block SHALL then go to CRYPT.
REQ-018 CRYPT encrypt, 11 edges: edge 0 state = in ^ rk0; edges 1-9 SubBytes, ShiftRows, MixColumns, AddRoundKey(rk_i); edge 10 SubBytes, ShiftRows, AddRoundKey(rk10).
REQ-019 CRYPT decrypt, 11 edges: edge 0 state = in ^ rk10; edges 1-9 InvShiftRows, InvSubBytes, AddRoundKey(rk_{10-i}), InvMixColumns; edge 10 InvShiftRows, InvSubBytes, AddRoundKey(rk0).
REQ-020 S-box/inverse S-box SHALL be combinational lookups or GF(2^8) logic; xtime SHALL be a shift with conditional ^0x1b.
REQ-021 Latency: WriteEn SHALL rise, with Result loaded, 21 edges after the accepting edge (1 ReadEn cycle overlapping KEYEXP); this latency SHALL be identical for encrypt and decrypt.
REQ-022 DONE: WriteEn=1 and Result stable SHALL hold until an edge samples WriteRy=1; at that edge WriteEn SHALL go 0 and the FSM SHALL return to IDLE.
REQ-023 After DONE, Result SHALL retain its value until the next DONE.
REQ-024 Input changes after acceptance SHALL be ignored until IDLE.
REQ-025 A new request present in IDLE after DONE SHALL be accepted on the next edge (back-to-back operation).
REQ-026 ReadRy/ReadyKey asserted outside IDLE SHALL be ignored; ReadEn SHALL not be asserted.

Reset
REQ-027 Rst=1 at an edge SHALL force IDLE, ReadEn=0, WriteEn=0, Result=0 and clear the internal state and keys, from any state including mid-KEYEXP/CRYPT, with the operation discarded.
REQ-028 Rst SHALL take priority over a simultaneous request.

Verification
REQ-029 Reset: Rst=1 for one edge -> ReadEn=0, WriteEn=0, Result=0.
REQ-030 Encrypt: PS=1, UserText=328831e0435a3137f6309807a88da234, Key=2b28ab097eaef7cf15d2154f16a6883c, ReadyKey=ReadRy=1, WriteRy=0 -> ReadEn high for exactly 1 cycle; WriteEn high 21 edges after acceptance; Result=3902dc1925dc116a8409850b1dfb9732, held indefinitely.
REQ-031 Decrypt: PS=0, UserText=3902dc1925dc116a8409850b1dfb9732, same Key -> Result=328831e0435a3137f6309807a88da234.
REQ-032 Encrypt: Key=0004080c0105090d02060a0e03070b0f, UserText=004488cc115599dd2266aaee3377bbff -> Result=696ad870c47bcdb4e004b7c5d830805a; decrypt of that value returns the plaintext.
REQ-033 Handshake: in DONE, pulse WriteRy=1 -> WriteEn=0 after that edge and Result unchanged; with the request still asserted, ReadEn pulses again on the next edge.
REQ-034 Abort/gating: Rst at the 12th edge after acceptance -> all outputs 0 and the next request completes correctly; ReadRy=1 with ReadyKey=0 -> no ReadEn and no WriteEn.

Source files
------------

// File: rtl/aes_128.sv
// aes_128: iterative AES-128 encrypt/decrypt engine, one round per clock.
//
// The module expands and stores all 11 round keys, then runs 11 cipher
// steps over the state. The request is acknowledged with a one-cycle
// ReadEn, and Result is held with WriteEn until the consumer accepts it.
//
// Ports:
//   Clk             rising-edge clock
//   Rst             synchronous active-high reset
//   ProgramSelector 1 = encrypt, 0 = decrypt (sampled at acceptance)
//   UserText[127:0] plaintext or ciphertext
//   Key[127:0]      cipher key
//   ReadyKey        Key valid
//   ReadRy          UserText valid
//   WriteRy         consumer accepts Result
//   ReadEn          one-cycle acknowledge that the inputs were captured
//   WriteEn         Result valid
//   Result[127:0]   ciphertext or plaintext
//
// Byte layout is row-major: [127:120] = s(r0,c0), [119:112] = s(r0,c1), ...
//
// state  | meaning
// IDLE   | waiting for ReadyKey & ReadRy
// KEYEXP | computing rk1..rk10, one per edge
// CRYPT  | 11 cipher steps (initial AddRoundKey + 10 rounds)
// DONE   | Result valid, waiting for WriteRy
module aes_128 (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         ProgramSelector,
    input  logic [127:0] UserText,
    input  logic [127:0] Key,
    input  logic         ReadyKey,
    input  logic         ReadRy,
    input  logic         WriteRy,
    output logic         ReadEn,
    output logic         WriteEn,
    output logic [127:0] Result
);

    typedef enum logic [1:0] {IDLE, KEYEXP, CRYPT, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         enc_q, enc_d;
    logic [127:0] text_q, text_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_d [0:10];
    logic [127:0] result_q, result_d;
    logic         read_en_q, read_en_d;
    logic         write_en_q, write_en_d;
    logic [127:0] rk_cur;
    logic [127:0] enc_t, dec_t, crypt_out;

    // MSB position of byte s(r,c) in the row-major layout
    function automatic int bi(input int r, input int c);
        return 127 - 8 * (4 * r + c);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 7; i++) r = gf_mul(gf_mul(r, r), a);
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input logic inv);
        logic [127:0] o;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv ? inv_sbox(v[127-8*k -: 8]) : sbox(v[127-8*k -: 8]);
        return o;
    endfunction

    // Row r rotates left by r for encryption, right by r for decryption
    function automatic logic [127:0] shift_rows(input logic [127:0] v, input logic inv);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (inv) o[bi(r, (c + r) % 4) -: 8] = v[bi(r, c) -: 8];
                else     o[bi(r, c) -: 8] = v[bi(r, (c + r) % 4) -: 8];
        return o;
    endfunction

    // Circulant matrix: row r uses coef[(j - r) mod 4] for input row j
    function automatic logic [127:0] mix_columns(input logic [127:0] v, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = v[bi(r, c) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[(j - r + 4) % 4], a[j]);
                o[bi(r, c) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0]  w [4];
        logic [31:0]  t;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            w[c] = {k[bi(0, c) -: 8], k[bi(1, c) -: 8], k[bi(2, c) -: 8], k[bi(3, c) -: 8]};
        t = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])}
            ^ {rcon, 24'h000000};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[bi(r, c) -: 8] = w[c][31-8*r -: 8];
        return o;
    endfunction

    // CRYPT counts down 10..0: step index is 10-cnt, so decryption simply
    // walks the key array with cnt itself.
    always_comb begin
        rk_cur = enc_q ? rk_q[4'd10 - cnt_q] : rk_q[cnt_q];
        enc_t  = shift_rows(sub_bytes(text_q, 1'b0), 1'b0);
        if (cnt_q != 4'd0) enc_t = mix_columns(enc_t, 1'b0);
        enc_t  = enc_t ^ rk_cur;
        dec_t  = sub_bytes(shift_rows(text_q, 1'b1), 1'b1) ^ rk_cur;
        if (cnt_q != 4'd0) dec_t = mix_columns(dec_t, 1'b1);
        if (cnt_q == 4'd10) crypt_out = text_q ^ rk_cur;
        else                crypt_out = enc_q ? enc_t : dec_t;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rcon_d     = rcon_q;
        enc_d      = enc_q;
        text_d     = text_q;
        rk_d       = rk_q;
        result_d   = result_q;
        read_en_d  = 1'b0;
        write_en_d = write_en_q;
        case (state_q)
            IDLE: begin
                if (ReadyKey && ReadRy) begin
                    text_d    = UserText;
                    rk_d[0]   = Key;
                    enc_d     = ProgramSelector;
                    read_en_d = 1'b1;
                    cnt_d     = 4'd9;
                    rcon_d    = 8'h01;
                    state_d   = KEYEXP;
                end
            end
            KEYEXP: begin
                rk_d[4'd10 - cnt_q] = key_step(rk_q[4'd9 - cnt_q], rcon_q);
                rcon_d = xtime(rcon_q);
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'd10;
                    state_d = CRYPT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CRYPT: begin
                text_d = crypt_out;
                if (cnt_q == 4'd0) begin
                    result_d   = crypt_out;
                    write_en_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (WriteRy) begin
                    write_en_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rcon_q     <= 8'h01;
            enc_q      <= 1'b0;
            text_q     <= '0;
            rk_q       <= '{default: '0};
            result_q   <= '0;
            read_en_q  <= 1'b0;
            write_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rcon_q     <= rcon_d;
            enc_q      <= enc_d;
            text_q     <= text_d;
            rk_q       <= rk_d;
            result_q   <= result_d;
            read_en_q  <= read_en_d;
            write_en_q <= write_en_d;
        end
    end

    assign ReadEn  = read_en_q;
    assign WriteEn = write_en_q;
    assign Result  = result_q;

endmodule

// File: tb/tb_aes_128.sv
// Bench for aes_128: directed known-answer vectors plus randomized
// encrypt/decrypt requests checked through a queue-based scoreboard.
module tb_aes_128;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         ProgramSelector;
    logic [127:0] UserText;
    logic [127:0] Key;
    logic         ReadyKey;
    logic         ReadRy;
    logic         WriteRy;
    logic         ReadEn;
    logic         WriteEn;
    logic [127:0] Result;

    aes_128 dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .ProgramSelector(ProgramSelector),
        .UserText       (UserText),
        .Key            (Key),
        .ReadyKey       (ReadyKey),
        .ReadRy         (ReadRy),
        .WriteRy        (WriteRy),
        .ReadEn         (ReadEn),
        .WriteEn        (WriteEn),
        .Result         (Result)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [127:0] exp;
        string        name;
    } exp_t;

    exp_t       sb_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    always @(posedge Clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- reference model (FIPS-197, column-major bytes) -------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from the generator-3 walk over GF(2^8)
    task automatic gen_sbox();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];
    endtask

    function automatic logic [127:0] aes_model(input bit enc, input logic [127:0] txt,
                                               input logic [127:0] key);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r+4*c] = txt[127-8*(4*r+c) -: 8];
        for (int c = 0; c < 4; c++)
            w[c] = {key[127-8*c -: 8], key[95-8*c -: 8], key[63-8*c -: 8], key[31-8*c -: 8]};
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n <= 10; n++) begin
            automatic int rnd = enc ? n : 10 - n;
            if (n > 0) begin
                if (enc) begin
                    for (int k = 0; k < 16; k++) st[k] = sb[st[k]];
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++) tmp[r+4*c] = st[r+4*((c+r)%4)];
                end else begin
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++) tmp[r+4*((c+r)%4)] = st[r+4*c];
                    for (int k = 0; k < 16; k++) tmp[k] = isb[tmp[k]];
                end
                st = tmp;
                if (enc && n < 10)
                    for (int c = 0; c < 4; c++) begin
                        a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                        st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                        st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                        st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                        st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                    end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r+4*c] = st[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
            if (!enc && n > 0 && n < 10)
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
                    st[4*c+1] = gm(a0, 9)  ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
                    st[4*c+2] = gm(a0, 13) ^ gm(a1, 9)  ^ gm(a2, 14) ^ gm(a3, 11);
                    st[4*c+3] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9)  ^ gm(a3, 14);
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[127-8*(4*r+c) -: 8] = st[r+4*c];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- monitor / scoreboard --------------------------------
    int           accept_cyc = 0;
    logic         re_prev    = 1'b0;
    logic         we_prev    = 1'b0;
    logic [127:0] held       = '0;

    always @(negedge Clk) begin
        if (Rst) begin
            re_prev = 1'b0;
            we_prev = 1'b0;
        end else begin
            if (ReadEn) begin
                check("readen_width", re_prev, 1'b0);
                accept_cyc = cyc;
            end
            if (WriteEn && !we_prev) begin
                check("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check(e.name, Result, e.exp);
                    check("latency", cyc - accept_cyc, 21);
                end
            end
            if (WriteEn && we_prev) check("result_hold", Result, held);
            if (!WriteEn && we_prev) check("result_retain", Result, held);
            if (WriteEn) held = Result;
            re_prev = ReadEn;
            we_prev = WriteEn;
        end
    end

    // ---------------- driver ----------------------------------------------
    task automatic issue(input bit ps, input logic [127:0] txt, input logic [127:0] key,
                         input logic [127:0] exp, input string name);
        int n;
        ProgramSelector = ps;
        UserText        = txt;
        Key             = key;
        ReadyKey        = 1'b1;
        ReadRy          = 1'b1;
        sb_q.push_back('{exp, name});
        n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (!ReadEn && n < 10);
        check("accept", ReadEn, 1'b1);
        ReadyKey        = 1'b0;
        ReadRy          = 1'b0;
        UserText        = rnd128();
        Key             = rnd128();
        ProgramSelector = ~ps;
    endtask

    // Busy-time request noise must be ignored by the DUT
    task automatic wait_done();
        int n;
        n = 0;
        while (!WriteEn && n < 40) begin
            ReadyKey = 1'($urandom_range(0, 1));
            ReadRy   = 1'($urandom_range(0, 1));
            UserText = rnd128();
            @(posedge Clk); #1;
            n++;
        end
        ReadyKey = 1'b0;
        ReadRy   = 1'b0;
        check("done_seen", WriteEn, 1'b1);
    endtask

    task automatic release_result(input int hold);
        repeat (hold) begin
            @(posedge Clk); #1;
        end
        WriteRy = 1'b1;
        @(posedge Clk); #1;
        WriteRy = 1'b0;
        check("we_drop", WriteEn, 1'b0);
    endtask

    task automatic run_op(input bit ps, input logic [127:0] txt, input logic [127:0] key,
                          input logic [127:0] exp, input string name);
        issue(ps, txt, key, exp, name);
        wait_done();
        release_result($urandom_range(0, 3));
    endtask

    localparam logic [127:0] K1 = 128'h2b28ab097eaef7cf15d2154f16a6883c;
    localparam logic [127:0] P1 = 128'h328831e0435a3137f6309807a88da234;
    localparam logic [127:0] C1 = 128'h3902dc1925dc116a8409850b1dfb9732;
    localparam logic [127:0] K2 = 128'h0004080c0105090d02060a0e03070b0f;
    localparam logic [127:0] P2 = 128'h004488cc115599dd2266aaee3377bbff;
    localparam logic [127:0] C2 = 128'h696ad870c47bcdb4e004b7c5d830805a;

    initial begin
        logic         seen;
        logic         ps;
        logic [127:0] txt, key;
        int           n;

        gen_sbox();
        Rst = 1'b1; ProgramSelector = 1'b0; UserText = '0; Key = '0;
        ReadyKey = 1'b0; ReadRy = 1'b0; WriteRy = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b0;
        check("rst_readen", ReadEn, 1'b0);
        check("rst_writeen", WriteEn, 1'b0);
        check("rst_result", Result, 128'h0);

        run_op(1'b1, P1, K1, C1, "enc_vec1");
        run_op(1'b0, C1, K1, P1, "dec_vec1");
        run_op(1'b1, P2, K2, C2, "enc_vec2");
        run_op(1'b0, C2, K2, P2, "dec_vec2");

        // Back-to-back: next request already waiting while in DONE
        issue(1'b1, P2, K2, C2, "b2b_first");
        wait_done();
        ProgramSelector = 1'b0; UserText = C1; Key = K1;
        ReadyKey = 1'b1; ReadRy = 1'b1;
        sb_q.push_back('{P1, "b2b_second"});
        repeat (2) begin
            @(posedge Clk); #1;
        end
        check("done_ignores_req", ReadEn, 1'b0);
        WriteRy = 1'b1;
        @(posedge Clk); #1;
        WriteRy = 1'b0;
        check("b2b_we_drop", WriteEn, 1'b0);
        check("b2b_no_early_ack", ReadEn, 1'b0);
        @(posedge Clk); #1;
        check("b2b_accept", ReadEn, 1'b1);
        ReadyKey = 1'b0; ReadRy = 1'b0; UserText = rnd128();
        wait_done();
        release_result(1);

        // Abort: reset on the 12th edge after acceptance
        ProgramSelector = 1'b1; UserText = P1; Key = K1;
        ReadyKey = 1'b1; ReadRy = 1'b1;
        n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (!ReadEn && n < 10);
        check("abort_accept", ReadEn, 1'b1);
        ReadyKey = 1'b0; ReadRy = 1'b0;
        repeat (11) begin
            @(posedge Clk); #1;
        end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        check("abort_readen", ReadEn, 1'b0);
        check("abort_writeen", WriteEn, 1'b0);
        check("abort_result", Result, 128'h0);
        run_op(1'b1, P1, K1, C1, "after_abort");

        // Gating: only one of the two valids asserted
        seen = 1'b0;
        ReadRy = 1'b1; ReadyKey = 1'b0;
        repeat (15) begin
            @(posedge Clk); #1;
            seen = seen | ReadEn | WriteEn;
        end
        ReadRy = 1'b0; ReadyKey = 1'b1;
        repeat (15) begin
            @(posedge Clk); #1;
            seen = seen | ReadEn | WriteEn;
        end
        ReadyKey = 1'b0;
        check("gating", seen, 1'b0);
        check("gating_result_retained", Result, C1);

        for (int i = 0; i < 8; i++) begin
            ps  = 1'($urandom_range(0, 1));
            txt = rnd128();
            key = rnd128();
            run_op(ps, txt, key, aes_model(ps, txt, key), ps ? "rand_enc" : "rand_dec");
        end

        @(posedge Clk); #1;
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
